// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPIO command decoder: GPO field positions,
// command codes and the decoder FSM state encoding.
package gpio_cmd_pkg;

    localparam int CMD_MSB  = 31;
    localparam int CMD_LSB  = 24;
    localparam int ENB_BIT  = 23;
    localparam int DATA_MSB = 22;

    typedef enum logic [7:0] {
        CMD_RESET       = 8'd0,
        CMD_EN_TX       = 8'd1,
        CMD_EN_RX       = 8'd2,
        CMD_PH_SEL      = 8'd3,
        CMD_RUN_MEM     = 8'd4,
        CMD_READ_MEM    = 8'd5,
        CMD_ADDR_MEM    = 8'd6,
        CMD_BER_S_I     = 8'd7,
        CMD_BER_S_Q     = 8'd8,
        CMD_BER_E_I     = 8'd9,
        CMD_BER_E_Q     = 8'd10,
        CMD_BER_H       = 8'd11,
        CMD_IS_MEM_FULL = 8'd12
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_MEM_CAP  = 2'd3
    } state_e;

endpackage

// File: rtl/gpio_edge_det.sv
// Rising-edge detector for the GPO enable bit. A level that is already high
// when reset is released is not treated as an edge until it has been seen low.
module gpio_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enb,
    output logic o_fire
);

    logic enb_prev_q, enb_prev_d;
    logic armed_q, armed_d;

    always_comb begin
        enb_prev_d = i_enb;
        armed_d    = armed_q | ~i_enb;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enb_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            enb_prev_q <= enb_prev_d;
            armed_q    <= armed_d;
        end
    end

    assign o_fire = i_enb & ~enb_prev_q & armed_q;

endmodule

// File: rtl/gpio_cmd_decoder.sv
// Decodes MicroBlaze GPO command words into modem datapath controls and
// drives the GPI readback word (BER counters, logger data, memory-full flag).
module gpio_cmd_decoder
    import gpio_cmd_pkg::*;
#(
    parameter int NB_GPIOS        = 32,
    parameter int NB_CMD          = 8,
    parameter int NB_DATA         = 23,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int NB_BER_CNT      = 64
) (
    input  logic                       clk100,
    input  logic                       i_resetn,
    input  logic [NB_GPIOS-1:0]        i_gpo,
    output logic [NB_GPIOS-1:0]        o_gpi,
    output logic                       o_rst,
    output logic                       o_enb_tx,
    output logic                       o_enb_rx,
    output logic [1:0]                 o_phase_sel,
    output logic                       o_run_log,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
    input  logic                       i_mem_full,
    input  logic [NB_GPIOS-1:0]        i_data_log_from_mem,
    input  logic [NB_BER_CNT-1:0]      i_ber_samp_i,
    input  logic [NB_BER_CNT-1:0]      i_ber_samp_q,
    input  logic [NB_BER_CNT-1:0]      i_ber_err_i,
    input  logic [NB_BER_CNT-1:0]      i_ber_err_q
);

    logic fire;

    state_e                     state_q, state_d;
    logic [NB_CMD-1:0]          cmd_q, cmd_d;
    logic [NB_DATA-1:0]         data_q, data_d;
    logic                       rst_q, rst_d;
    logic                       run_q, run_d;
    logic                       enb_tx_q, enb_tx_d;
    logic                       enb_rx_q, enb_rx_d;
    logic [1:0]                 phase_q, phase_d;
    logic                       read_q, read_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB_GPIOS-1:0]        gpi_q, gpi_d;
    logic [NB_BER_CNT-1:0]      ber_shadow_q, ber_shadow_d;
    logic [NB_BER_CNT-1:0]      ber_sel;
    logic                       data_hi_unused;

    gpio_edge_det u_edge_det (
        .clk    (clk100),
        .rst_n  (i_resetn),
        .i_enb  (i_gpo[ENB_BIT]),
        .o_fire (fire)
    );

    // Payload bits above the address field carry no meaning for any command.
    assign data_hi_unused = ^data_q[NB_DATA-1:BRAM_ADDR_WIDTH];

    always_comb begin
        ber_sel = i_ber_samp_i;
        case (cmd_q)
            CMD_BER_S_Q: ber_sel = i_ber_samp_q;
            CMD_BER_E_I: ber_sel = i_ber_err_i;
            CMD_BER_E_Q: ber_sel = i_ber_err_q;
            default:     ber_sel = i_ber_samp_i;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        rst_d        = 1'b0;
        run_d        = 1'b0;
        enb_tx_d     = enb_tx_q;
        enb_rx_d     = enb_rx_q;
        phase_d      = phase_q;
        read_d       = read_q;
        addr_d       = addr_q;
        gpi_d        = gpi_q;
        ber_shadow_d = ber_shadow_q;

        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    cmd_d   = i_gpo[CMD_MSB:CMD_LSB];
                    data_d  = i_gpo[DATA_MSB:0];
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_RESET:    rst_d    = 1'b1;
                    CMD_EN_TX:    enb_tx_d = data_q[0];
                    CMD_EN_RX:    enb_rx_d = data_q[0];
                    CMD_PH_SEL:   phase_d  = data_q[1:0];
                    CMD_RUN_MEM:  run_d    = 1'b1;
                    CMD_READ_MEM: read_d   = data_q[0];
                    CMD_ADDR_MEM: begin
                        addr_d  = data_q[BRAM_ADDR_WIDTH-1:0];
                        state_d = ST_MEM_WAIT;
                    end
                    // Both counter halves are frozen from the same edge so BER_H stays coherent.
                    CMD_BER_S_I, CMD_BER_S_Q, CMD_BER_E_I, CMD_BER_E_Q: begin
                        ber_shadow_d = ber_sel;
                        gpi_d        = ber_sel[NB_GPIOS-1:0];
                    end
                    CMD_BER_H:       gpi_d = ber_shadow_q[NB_BER_CNT-1 -: NB_GPIOS];
                    CMD_IS_MEM_FULL: gpi_d = {{(NB_GPIOS-1){1'b0}}, i_mem_full};
                    default: ;
                endcase
            end

            // The BRAM registers the new address here; its data is sampled one edge later.
            ST_MEM_WAIT: state_d = ST_MEM_CAP;

            ST_MEM_CAP: begin
                gpi_d   = i_data_log_from_mem;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            data_q       <= '0;
            rst_q        <= 1'b0;
            run_q        <= 1'b0;
            enb_tx_q     <= 1'b0;
            enb_rx_q     <= 1'b0;
            phase_q      <= 2'd0;
            read_q       <= 1'b0;
            addr_q       <= '0;
            gpi_q        <= '0;
            ber_shadow_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            rst_q        <= rst_d;
            run_q        <= run_d;
            enb_tx_q     <= enb_tx_d;
            enb_rx_q     <= enb_rx_d;
            phase_q      <= phase_d;
            read_q       <= read_d;
            addr_q       <= addr_d;
            gpi_q        <= gpi_d;
            ber_shadow_q <= ber_shadow_d;
        end
    end

    assign o_gpi             = gpi_q;
    assign o_rst             = rst_q;
    assign o_run_log         = run_q;
    assign o_enb_tx          = enb_tx_q;
    assign o_enb_rx          = enb_rx_q;
    assign o_phase_sel       = phase_q;
    assign o_read_log        = read_q;
    assign o_addr_log_to_mem = addr_q;

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Self-checking bench for gpio_cmd_decoder: directed steps followed by random
// commands, all compared against a command-level behavioural model.
module tb_gpio_cmd_decoder;

    localparam logic [7:0] C_RESET = 8'd0, C_EN_TX = 8'd1, C_EN_RX = 8'd2, C_PH = 8'd3;
    localparam logic [7:0] C_RUN = 8'd4, C_READ = 8'd5, C_ADDR = 8'd6;
    localparam logic [7:0] C_BSI = 8'd7, C_BSQ = 8'd8, C_BEI = 8'd9, C_BEQ = 8'd10;
    localparam logic [7:0] C_BH = 8'd11, C_FULL = 8'd12;

    logic        clk100 = 1'b0;
    logic        i_resetn;
    logic [31:0] i_gpo;
    logic [31:0] o_gpi;
    logic        o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
    logic [1:0]  o_phase_sel;
    logic [14:0] o_addr_log_to_mem;
    logic        i_mem_full;
    logic [31:0] i_data_log_from_mem;
    logic [63:0] i_ber_samp_i, i_ber_samp_q, i_ber_err_i, i_ber_err_q;

    gpio_cmd_decoder dut (
        .clk100              (clk100),
        .i_resetn            (i_resetn),
        .i_gpo               (i_gpo),
        .o_gpi               (o_gpi),
        .o_rst               (o_rst),
        .o_enb_tx            (o_enb_tx),
        .o_enb_rx            (o_enb_rx),
        .o_phase_sel         (o_phase_sel),
        .o_run_log           (o_run_log),
        .o_read_log          (o_read_log),
        .o_addr_log_to_mem   (o_addr_log_to_mem),
        .i_mem_full          (i_mem_full),
        .i_data_log_from_mem (i_data_log_from_mem),
        .i_ber_samp_i        (i_ber_samp_i),
        .i_ber_samp_q        (i_ber_samp_q),
        .i_ber_err_i         (i_ber_err_i),
        .i_ber_err_q         (i_ber_err_q)
    );

    always #5 clk100 = ~clk100;

    int n_cmp, n_mis;
    int hold_left;
    bit ber_inc;

    // Command-level model of the visible state.
    logic        m_tx, m_rx, m_read, exp_rst, exp_run;
    logic [1:0]  m_ph;
    logic [14:0] m_addr;
    logic [31:0] m_gpi;
    logic [63:0] m_shadow;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tx = 0; m_rx = 0; m_read = 0; m_ph = 0; m_addr = 0;
        m_gpi = 0; m_shadow = 0; exp_rst = 0; exp_run = 0;
    endtask

    // Applies one command using the environment values present at the execute edge.
    task automatic model_exec(input logic [7:0] cmd, input logic [22:0] data);
        logic [63:0] ctr;
        exp_rst = 0;
        exp_run = 0;
        case (cmd)
            C_RESET: exp_rst = 1;
            C_EN_TX: m_tx = data[0];
            C_EN_RX: m_rx = data[0];
            C_PH:    m_ph = data[1:0];
            C_RUN:   exp_run = 1;
            C_READ:  m_read = data[0];
            C_ADDR:  m_addr = data[14:0];
            C_BSI, C_BSQ, C_BEI, C_BEQ: begin
                ctr = (cmd == C_BSI) ? i_ber_samp_i :
                      (cmd == C_BSQ) ? i_ber_samp_q :
                      (cmd == C_BEI) ? i_ber_err_i : i_ber_err_q;
                m_shadow = ctr;
                m_gpi    = ctr[31:0];
            end
            C_BH:   m_gpi = m_shadow[63:32];
            C_FULL: m_gpi = {31'b0, i_mem_full};
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, " enb_tx"}, o_enb_tx, m_tx);
        check({tag, " enb_rx"}, o_enb_rx, m_rx);
        check({tag, " phase"}, o_phase_sel, m_ph);
        check({tag, " read_log"}, o_read_log, m_read);
        check({tag, " addr"}, o_addr_log_to_mem, m_addr);
        check({tag, " gpi"}, o_gpi, m_gpi);
        check({tag, " rst"}, o_rst, exp_rst);
        check({tag, " run_log"}, o_run_log, exp_run);
    endtask

    // One clock; the BRAM model returns {17'b0, addr} for the address seen at this edge.
    task automatic step();
        logic [14:0] a;
        a = o_addr_log_to_mem;
        @(posedge clk100);
        #1;
        i_data_log_from_mem = {17'b0, a};
        if (ber_inc) i_ber_err_q = i_ber_err_q + 64'd1;
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) i_gpo[23] = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] cmd, input logic [22:0] data, input int hold,
                        input string tag);
        i_gpo = {cmd, 1'b1, data};
        hold_left = hold;
        step();                                   // fire edge k
        model_exec(cmd, data);
        step();                                   // execute edge k+1
        check_all({tag, " k+1"});
        exp_rst = 0;
        exp_run = 0;
        step();                                   // k+2
        check_all({tag, " k+2"});
        if (cmd == C_ADDR) begin
            step();                               // k+3
            m_gpi = {17'b0, m_addr};
            check_all({tag, " k+3"});
        end
        while (hold_left > 0) begin
            step();
            check_all({tag, " held"});
        end
        step();
    endtask

    logic [22:0] ph_data [5] = '{23'd0, 23'd1, 23'd2, 23'd3, 23'h7};
    logic [1:0]  ph_exp  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rc;
        logic [22:0] rd;
        n_cmp = 0; n_mis = 0; hold_left = 0; ber_inc = 0;
        i_resetn = 1'b0;
        i_gpo = {C_EN_TX, 1'b1, 23'd1};
        i_mem_full = 1'b0;
        i_data_log_from_mem = '0;
        i_ber_samp_i = '0; i_ber_samp_q = '0; i_ber_err_i = '0; i_ber_err_q = '0;
        model_reset();

        step(); step();
        check_all("reset");
        i_resetn = 1'b1;
        step(); step(); step();
        check_all("enable high out of reset");
        i_gpo[23] = 1'b0;
        step();

        send(C_EN_TX, 23'd1, 1, "en_tx");
        check("en_tx level", o_enb_tx, 1'b1);
        send(C_EN_RX, 23'd1, 1, "en_rx");
        check("en_rx level", o_enb_rx, 1'b1);

        for (int i = 0; i < 5; i++) begin
            send(C_PH, ph_data[i], 1, "ph_sel");
            check("ph_sel value", o_phase_sel, ph_exp[i]);
        end

        send(C_RESET, 23'h12345, 10, "rst held");
        send(C_RUN, 23'h00001, 10, "run held");

        ber_inc = 1'b1;
        i_ber_err_q = 64'h0000_0001_FFFF_FFFE;
        send(C_BEQ, 23'd0, 1, "ber_e_q");
        check("ber low word", o_gpi, 32'hFFFF_FFFF);
        step(); step();
        send(C_BH, 23'd0, 1, "ber_h");
        check("ber high word", o_gpi, 32'h0000_0001);
        ber_inc = 1'b0;

        i_gpo = {C_ADDR, 1'b1, 23'h35EB1C};
        hold_left = 1;
        step();
        model_exec(C_ADDR, 23'h35EB1C);
        step();
        check_all("mem k+1");
        check("mem addr", o_addr_log_to_mem, 15'h6B1C);
        i_gpo = {C_EN_TX, 1'b1, 22'd0, ~m_tx};
        hold_left = 2;
        step();
        check_all("mem k+2");
        step();
        m_gpi = {17'b0, m_addr};
        check_all("mem k+3");
        check("mem gpi", o_gpi, 32'h0000_6B1C);
        step(); step();
        check_all("mem dropped edge");

        send(C_READ, 23'd1, 1, "read_mem");
        i_mem_full = 1'b1;
        send(C_FULL, 23'd0, 1, "mem_full");
        i_mem_full = 1'b0;
        send(C_PH, 23'd2, 1, "ph before reset");

        i_gpo = {C_ADDR, 1'b1, 23'h00777};
        hold_left = 1;
        step();
        model_exec(C_ADDR, 23'h00777);
        step();
        check_all("pre midreset");
        i_resetn = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        #1;
        i_resetn = 1'b1;
        step(); step(); step();
        check_all("after midreset");
        send(C_EN_TX, 23'd1, 1, "idle after reset");

        send(8'hFF, 23'h7FFFFF, 1, "unknown cmd");

        for (int i = 0; i < 40; i++) begin
            rc = 8'($urandom_range(0, 15));
            rd = 23'($urandom);
            i_ber_samp_i = {$urandom, $urandom};
            i_ber_samp_q = {$urandom, $urandom};
            i_ber_err_i  = {$urandom, $urandom};
            i_ber_err_q  = {$urandom, $urandom};
            i_mem_full   = 1'($urandom_range(0, 1));
            send(rc, rd, int'($urandom_range(1, 3)), $sformatf("rand%0d cmd%0d", i, rc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
